// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared VRAM geometry constants and the tile-line fetch state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

  localparam int TILE_LINE_W      = 256;
  localparam int TILE_LINE_ADDR_W = 12;
  localparam int TILE_PIX_ADDR_W  = 15;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_CAPTURE = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/tile_line_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tile_line_serializer
// Description : Holds the ACTIVE tile line and streams its pixels one per
//               accepted handshake, optionally right-to-left.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_line_serializer
  import vram_pkg::*;
#(
  parameter int PIXEL_W     = 8,
  parameter int LINE_PIXELS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TILE_LINE_W-1:0] load_line,
  input  logic                   load_flip,
  output logic                   line_done,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [PIXEL_W-1:0]     pix_data,
  output logic                   pix_last
);

  localparam int CNT_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LINE_PIXELS - 1);

  logic [TILE_LINE_W-1:0] r_line;
  logic                   r_flip;
  logic                   r_full;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_idx;
  logic                   w_consume;

  assign w_consume = r_full && pix_ready;
  assign pix_valid = r_full;
  assign pix_last  = r_full && (r_cnt == C_LAST);
  assign line_done = w_consume && pix_last;
  assign pix_data  = r_line[int'(w_idx) * PIXEL_W +: PIXEL_W];

  // Map the emission count to a pixel slot, mirrored when flipping.
  always_comb begin
    w_idx = r_flip ? (C_LAST - r_cnt) : r_cnt;
  end

  // ACTIVE slot: a load always lands on an empty or just-emptied slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line <= '0;
      r_flip <= 1'b0;
      r_full <= 1'b0;
    end else if (load) begin
      r_line <= load_line;
      r_flip <= load_flip;
      r_full <= 1'b1;
    end else if (line_done) begin
      r_full <= 1'b0;
    end
  end

  // Pixel counter advances only on a consumed pixel and wraps after the last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_consume) begin
      r_cnt <= pix_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tile_line_reader.sv
`default_nettype none
// ============================================================================
// Module      : tile_line_reader
// Description : Fetches 256-bit tile lines from tile memory into a PENDING
//               slot and hands them to the serializer for gap-free pixel
//               streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_line_reader
  import vram_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int PIXEL_W      = 8,
  parameter int LINE_PIXELS  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [TILE_LINE_ADDR_W-1:0] req_line,
  input  logic                        req_flip_x,
  output logic [TILE_LINE_ADDR_W-1:0] read_addr,
  input  logic [TILE_LINE_W-1:0]      read_data,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic [PIXEL_W-1:0]          pix_data,
  output logic                        pix_last
);

  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

  fetch_state_t           r_state;
  fetch_state_t           w_state_next;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic                   r_started;
  logic                   r_req_flip;
  logic                   r_pend_full;
  logic [TILE_LINE_W-1:0] r_pend_line;
  logic                   r_pend_flip;

  logic                   w_accept;
  logic                   w_capture;
  logic                   w_line_done;
  logic                   w_take;
  logic                   w_bypass;
  logic                   w_load;
  logic [TILE_LINE_W-1:0] w_load_line;
  logic                   w_load_flip;

  // r_started keeps req_ready low until the first edge after reset release.
  assign req_ready   = r_started && (r_state == FETCH_IDLE) && !r_pend_full;
  assign w_accept    = req_valid && req_ready;
  assign w_capture   = (r_state == FETCH_CAPTURE);
  assign w_take      = !pix_valid || w_line_done;
  // PENDING is always empty while a fetch is in flight, so a capture that
  // coincides with the end of a line goes straight to ACTIVE.
  assign w_bypass    = w_capture && w_line_done;
  assign w_load      = (r_pend_full && w_take) || w_bypass;
  assign w_load_line = r_pend_full ? r_pend_line : read_data;
  assign w_load_flip = r_pend_full ? r_pend_flip : r_req_flip;

  // Fetch state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Fetch next-state: accept, wait out the memory latency, capture.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_IDLE:    if (w_accept) w_state_next = FETCH_WAIT;
      FETCH_WAIT:    if (r_wait_cnt == C_WAIT_LAST) w_state_next = FETCH_CAPTURE;
      FETCH_CAPTURE: w_state_next = FETCH_IDLE;
      default:       w_state_next = FETCH_IDLE;
    endcase
  end

  // Latency counter runs only while waiting for read_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == FETCH_WAIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Request side: latch address and flip on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_started  <= 1'b0;
      read_addr  <= '0;
      r_req_flip <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (w_accept) begin
        read_addr  <= req_line;
        r_req_flip <= req_flip_x;
      end
    end
  end

  // PENDING slot: filled on capture unless bypassed, drained into ACTIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_full <= 1'b0;
      r_pend_line <= '0;
      r_pend_flip <= 1'b0;
    end else if (r_pend_full && w_take) begin
      r_pend_full <= 1'b0;
    end else if (w_capture && !w_bypass) begin
      r_pend_full <= 1'b1;
      r_pend_line <= read_data;
      r_pend_flip <= r_req_flip;
    end
  end

  tile_line_serializer #(
    .PIXEL_W     (PIXEL_W),
    .LINE_PIXELS (LINE_PIXELS)
  ) u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_line (w_load_line),
    .load_flip (w_load_flip),
    .line_done (w_line_done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_last  (pix_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_tile_line_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_line_reader
// Description : Self-checking bench for tile_line_reader with a preloaded
//               tile-memory model and a queue-based pixel reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_line_reader;
  import vram_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic                        req_valid = 1'b0;
  logic                        req_ready;
  logic [TILE_LINE_ADDR_W-1:0] req_line = '0;
  logic                        req_flip_x = 1'b0;
  logic [TILE_LINE_ADDR_W-1:0] read_addr;
  logic [TILE_LINE_W-1:0]      read_data;
  logic                        pix_valid;
  logic                        pix_ready;
  logic [7:0]                  pix_data;
  logic                        pix_last;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       first;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         pix_seen = 0;
  int         ready_pct = 100;
  logic [7:0] first_pix = '0;
  logic [7:0] last_pix = '0;
  logic [15:0] vram_words [0:65535];

  tile_line_reader #(
    .READ_LATENCY (1),
    .PIXEL_W      (8),
    .LINE_PIXELS  (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_line   (req_line),
    .req_flip_x (req_flip_x),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_last   (pix_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tile memory: pair address p holds {p[7:0]+1, p[7:0]}; one line is 16 words.
  initial begin
    for (int w = 0; w < 65536; w++) begin
      logic [16:0] p;
      p = 17'(w * 2);
      vram_words[w] = {p[7:0] + 8'd1, p[7:0]};
    end
  end

  // One-cycle registered read.
  always @(posedge clk) begin
    for (int j = 0; j < 16; j++) begin
      read_data[16*j +: 16] <= vram_words[{read_addr, 4'(j)}];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a line L contributes pixels (L*32+k) mod 256 in emission order.
  task automatic push_line(input logic [11:0] line, input logic flip);
    exp_t e;
    int   k;
    for (int i = 0; i < 32; i++) begin
      k = flip ? (31 - i) : i;
      e.data  = 8'((int'(line) * 32 + k) & 255);
      e.last  = (i == 31);
      e.first = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Caller is just after a rising edge; returns just after the accepting edge.
  task automatic do_req(input logic [11:0] line, input logic flip, output int acc_cyc);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    req_valid  = 1'b1;
    req_line   = line;
    req_flip_x = flip;
    while (n < 500) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    if (ok) push_line(line, flip);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || pix_valid) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Downstream back-pressure.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Compare process: every consumed pixel against the model, plus stall hold.
  initial begin
    logic       stall;
    logic [7:0] sd;
    logic       sl;
    exp_t       e;
    stall = 1'b0;
    sd    = '0;
    sl    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_valid", 32'(pix_valid), 32'd1);
          check("stall_data", 32'(pix_data), 32'(sd));
          check("stall_last", 32'(pix_last), 32'(sl));
        end
        if (pix_valid && exp_q.size() == 0) begin
          check("unexpected_pixel", 32'(pix_valid), 32'd0);
        end else if (pix_valid && pix_ready) begin
          e = exp_q.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.data));
          check("pix_last", 32'(pix_last), 32'(e.last));
          if (e.first) first_pix = pix_data;
          if (e.last)  last_pix  = pix_data;
          pix_seen++;
        end
        stall = pix_valid && !pix_ready;
        sd    = pix_data;
        sl    = pix_last;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, lat, gaps, base;
    #1;
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data",  32'(pix_data),  32'd0);
    check("rst_pix_last",  32'(pix_last),  32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_read_addr", 32'(read_addr), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(req_ready), 32'd1);

    // V1: line 0, forward, latency from acceptance.
    do_req(12'd0, 1'b0, a0);
    check("v1_read_addr", 32'(read_addr), 32'd0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pix_valid) break;
      lat++;
    end
    check("v1_latency", 32'(lat), 32'd3);
    drain();
    check("v1_first", 32'(first_pix), 32'h00);
    check("v1_last",  32'(last_pix),  32'h1F);

    // V2: line 0, flipped.
    do_req(12'd0, 1'b1, a0);
    drain();
    check("v2_first", 32'(first_pix), 32'h1F);
    check("v2_last",  32'(last_pix),  32'h00);

    // V3: back-to-back lines 0 and 1, no bubbles, req_ready low while PENDING full.
    base = pix_seen;
    do_req(12'd0, 1'b0, a0);
    do_req(12'd1, 1'b0, a1);
    check("v3_accept_gap", 32'(a1 - a0), 32'd4);
    gaps = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 5) check("v3_ready_low_pending", 32'(req_ready), 32'd0);
      if (exp_q.size() > 0 && !pix_valid) gaps++;
      if (exp_q.size() == 0 && !pix_valid) break;
    end
    check("v3_gaps", 32'(gaps), 32'd0);
    drain();
    check("v3_count", 32'(pix_seen - base), 32'd64);
    check("v3_last",  32'(last_pix), 32'h3F);

    // V4: 30% downstream readiness.
    ready_pct = 30;
    do_req(12'd0, 1'b0, a0);
    drain();
    ready_pct = 100;
    check("v4_first", 32'(first_pix), 32'h00);
    check("v4_last",  32'(last_pix),  32'h1F);

    // V5: reset in the middle of line 5.
    base = pix_seen;
    do_req(12'd5, 1'b0, a0);
    for (int i = 0; i < 100 && pix_seen < base + 10; i++) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("v5_async_valid", 32'(pix_valid), 32'd0);
    check("v5_async_data",  32'(pix_data),  32'd0);
    check("v5_async_last",  32'(pix_last),  32'd0);
    check("v5_async_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("v5_ready_before_edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("v5_ready_after_edge", 32'(req_ready), 32'd1);
    check("v5_no_residue", 32'(pix_valid), 32'd0);
    do_req(12'd6, 1'b0, a0);
    drain();
    check("v5_first", 32'(first_pix), 32'hC0);
    check("v5_last",  32'(last_pix),  32'hDF);

    // V6: top line address.
    do_req(12'hFFF, 1'b0, a0);
    check("v6_read_addr", 32'(read_addr), 32'hFFF);
    drain();
    check("v6_first", 32'(first_pix), 32'hE0);
    check("v6_last",  32'(last_pix),  32'hFF);

    // Randomized lines, flips, pairs and back-pressure.
    for (int it = 0; it < 10; it++) begin
      ready_pct = $urandom_range(20, 100);
      do_req(12'($urandom), 1'($urandom), a0);
      if ($urandom_range(0, 1) == 1) do_req(12'($urandom), 1'($urandom), a1);
      drain();
    end
    ready_pct = 100;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
